// File: rtl/scrypt_header_loader.sv
// Header loader for the HMAC-SHA256 key-hash stage: collects twenty 32-bit
// header words, launches the hash stage, captures its result and optionally
// sweeps the nonce (word 19) to produce one result per nonce.
module scrypt_header_loader #(
   parameter int unsigned NONCE_STEP     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         n_rst,        // active-high asynchronous reset
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_word,
   input  logic [31:0]  sweep_count,
   input  logic         abort,
   output logic [639:0] hmac_data,
   output logic         hmac_enable,
   input  logic [255:0] hmac_hash,
   input  logic         hmac_done,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [255:0] res_hash,
   output logic [31:0]  res_nonce,
   output logic         busy,
   output logic         timeout_err
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {StLoad, StStart, StWait, StResult, StDrain} state_e;

   state_e          state_q;
   logic [4:0]      word_cnt_q;
   logic [31:0]     remaining_q;
   logic [CntW-1:0] wait_cnt_q;
   logic [639:0]    data_q;
   logic            enable_q;
   logic            res_valid_q;
   logic [255:0]    res_hash_q;
   logic [31:0]     res_nonce_q;
   logic            timeout_err_q;

   logic            in_fire;
   logic            wait_expired;
   logic [CntW-1:0] wait_cnt_inc;
   logic [9:0]      slot_lsb;

   assign in_ready     = (state_q == StLoad);
   assign busy         = (state_q != StLoad);
   assign in_fire      = in_valid & in_ready;
   assign wait_cnt_inc = wait_cnt_q + CntW'(1);
   // Expiry is taken on the cycle whose incremented count reaches TIMEOUT_CYCLES-1,
   // so the whole window from the enable pulse spans TIMEOUT_CYCLES cycles.
   assign wait_expired = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 2));
   // Word i lives at [639-32i -: 32], i.e. its LSB is at 32*(19-i).
   assign slot_lsb     = {5'd19 - word_cnt_q, 5'd0};

   assign hmac_data    = data_q;
   assign hmac_enable  = enable_q;
   assign res_valid    = res_valid_q;
   assign res_hash     = res_hash_q;
   assign res_nonce    = res_nonce_q;
   assign timeout_err  = timeout_err_q;

   // Single-block FSM: header load, hash launch, result handoff, nonce sweep and abort drain.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state_q       <= StLoad;
         word_cnt_q    <= '0;
         remaining_q   <= '0;
         wait_cnt_q    <= '0;
         data_q        <= '0;
         enable_q      <= 1'b0;
         res_valid_q   <= 1'b0;
         res_hash_q    <= '0;
         res_nonce_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         enable_q <= 1'b0;
         unique case (state_q)
            StLoad: begin
               if (abort) begin
                  word_cnt_q <= '0;
               end else if (in_fire) begin
                  data_q[slot_lsb +: 32] <= in_word;
                  if (word_cnt_q == 5'd0) begin
                     remaining_q   <= sweep_count;
                     timeout_err_q <= 1'b0;
                  end
                  if (word_cnt_q == 5'd19) begin
                     word_cnt_q <= '0;
                     enable_q   <= 1'b1;
                     state_q    <= StStart;
                  end else begin
                     word_cnt_q <= word_cnt_q + 5'd1;
                  end
               end
            end
            StStart: begin
               // The enable pulse is already out, so an abort must still drain the stage.
               wait_cnt_q <= '0;
               state_q    <= abort ? StDrain : StWait;
            end
            StWait: begin
               if (abort) begin
                  // A stage that completes in the abort cycle is already idle.
                  if (hmac_done || wait_expired) begin
                     state_q <= StLoad;
                  end else begin
                     wait_cnt_q <= wait_cnt_inc;
                     state_q    <= StDrain;
                  end
               end else if (hmac_done) begin
                  res_hash_q  <= hmac_hash;
                  res_nonce_q <= data_q[31:0];
                  res_valid_q <= 1'b1;
                  state_q     <= StResult;
               end else if (wait_expired) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= StLoad;
               end else begin
                  wait_cnt_q <= wait_cnt_inc;
               end
            end
            StResult: begin
               if (abort) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StLoad;
               end else if (res_ready) begin
                  res_valid_q <= 1'b0;
                  if (remaining_q != 32'd0) begin
                     remaining_q  <= remaining_q - 32'd1;
                     data_q[31:0] <= data_q[31:0] + 32'(NONCE_STEP);
                     enable_q     <= 1'b1;
                     state_q      <= StStart;
                  end else begin
                     state_q <= StLoad;
                  end
               end
            end
            StDrain: begin
               // Hash from an aborted job is discarded; expiry here is silent.
               if (hmac_done || wait_expired) begin
                  state_q <= StLoad;
               end else begin
                  wait_cnt_q <= wait_cnt_inc;
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

endmodule

// File: tb/tb_scrypt_header_loader.sv
// Self-checking bench for scrypt_header_loader: vector table, randomized jobs
// against a nonce/hash reference model, and hand sequences for abort/timeout/reset.
module tb_scrypt_header_loader;

   localparam int unsigned Step    = 1;
   localparam int unsigned Timeout = 16;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_word;
   logic [31:0]  sweep_count;
   logic         abort;
   logic [639:0] hmac_data;
   logic         hmac_enable;
   logic [255:0] hmac_hash;
   logic         hmac_done;
   logic         res_valid;
   logic         res_ready;
   logic [255:0] res_hash;
   logic [31:0]  res_nonce;
   logic         busy;
   logic         timeout_err;

   always #5 clk = ~clk;

   scrypt_header_loader #(
      .NONCE_STEP    (Step),
      .TIMEOUT_CYCLES(Timeout)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .sweep_count(sweep_count),
      .abort      (abort),
      .hmac_data  (hmac_data),
      .hmac_enable(hmac_enable),
      .hmac_hash  (hmac_hash),
      .hmac_done  (hmac_done),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_hash   (res_hash),
      .res_nonce  (res_nonce),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   int passed = 0;
   int total  = 0;

   // Hash stage model controls (written by the main sequence only)
   int           stage_delay = 10;   // 0 = never completes
   bit           stage_fixed = 1'b0;
   logic [255:0] stage_fixed_hash = {32{8'hAA}};
   int           kill_req = 0;
   // Written by the stage model only
   int           en_count = 0;

   typedef logic [31:0] words_t [20];

   function automatic logic [255:0] hashf(input logic [639:0] d);
      return d[639:384] ^ {8{d[31:0]}};
   endfunction

   function automatic logic [639:0] pack(input words_t w);
      logic [639:0] d;
      d = '0;
      for (int i = 0; i < 20; i++) d[639 - 32*i -: 32] = w[i];
      return d;
   endfunction

   // Expected hash for a given header with word 19 replaced by nonce
   function automatic logic [255:0] model_hash(input words_t w, input logic [31:0] nonce);
      words_t m;
      m = w;
      m[19] = nonce;
      return stage_fixed ? stage_fixed_hash : hashf(pack(m));
   endfunction

   // Hash stage: latches the operand on enable, pulses done stage_delay cycles later
   initial begin : stage
      int cnt;
      int kill_seen;
      logic [639:0] op;
      cnt = 0;
      kill_seen = 0;
      op = '0;
      hmac_done = 1'b0;
      hmac_hash = '0;
      forever begin
         @(posedge clk);
         #1;
         hmac_done = 1'b0;
         if (kill_req != kill_seen) begin
            kill_seen = kill_req;
            cnt = 0;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               hmac_done = 1'b1;
               hmac_hash = stage_fixed ? stage_fixed_hash : hashf(op);
            end
         end
         if (hmac_enable) begin
            en_count++;
            op  = hmac_data;
            cnt = stage_delay;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " in_ready"}, in_ready, 1);
      check({tag, " busy"}, busy, 0);
      check({tag, " hmac_enable"}, hmac_enable, 0);
      check({tag, " res_valid"}, res_valid, 0);
      check({tag, " timeout_err"}, timeout_err, 0);
      check({tag, " hmac_data"}, hmac_data, 0);
      check({tag, " res_hash"}, res_hash, 0);
      check({tag, " res_nonce"}, res_nonce, 0);
   endtask

   task automatic random_words(output words_t w);
      for (int i = 0; i < 20; i++) w[i] = $urandom();
   endtask

   // Called at a negedge; returns at the negedge after the n-th handshake
   task automatic send_words(input words_t w, input int n, input logic [31:0] sweep);
      int k;
      for (int i = 0; i < n; i++) begin
         in_valid    = 1'b1;
         in_word     = w[i];
         sweep_count = (i == 0) ? sweep : $urandom();
         k = 0;
         while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
         end
         if (!in_ready) begin
            check("in_ready wait", in_ready, 1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid    = 1'b0;
      sweep_count = $urandom();
   endtask

   task automatic wait_res(output bit ok);
      int k;
      k = 0;
      while (!res_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      ok = res_valid;
      if (!ok) check("res_valid wait", res_valid, 1);
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic run_job(input words_t w, input int sweep, input int delay, input int stall_max,
                          output int nres, output logic [31:0] last_nonce);
      int base;
      bit ok;
      logic [31:0] nonce;
      stage_delay = delay;
      base = en_count;
      nres = 0;
      last_nonce = 'x;
      send_words(w, 20, sweep);
      check("enable after last word", hmac_enable, 1);
      check("hmac_data", hmac_data, pack(w));
      nonce = w[19];
      for (int k = 0; k <= sweep; k++) begin
         wait_res(ok);
         if (!ok) break;
         check("res_nonce", res_nonce, nonce);
         check("res_hash", res_hash, model_hash(w, nonce));
         repeat ($urandom_range(stall_max, 0)) @(negedge clk);
         handshake();
         nres++;
         last_nonce = nonce;
         nonce = nonce + Step;
      end
      check("busy after job", busy, 0);
      check("enable count", en_count - base, sweep + 1);
   endtask

   typedef struct {
      logic [31:0] w19;
      int          sweep;
      int          delay;
      logic [31:0] exp_last;
      int          exp_n;
   } vec_t;

   initial begin : main
      vec_t        vecs[5];
      words_t      w;
      int          nres;
      int          base;
      int          idx;
      bit          ok;
      bit          seen_valid;
      logic [31:0] last;

      vecs[0] = '{32'h0000_0013, 0, 10, 32'h0000_0013, 1};
      vecs[1] = '{32'hFFFF_FFFF, 2, 10, 32'h0000_0001, 3};
      vecs[2] = '{32'h7FFF_FFFE, 3, 3,  32'h8000_0001, 4};
      vecs[3] = '{32'h0000_0100, 1, 1,  32'h0000_0101, 2};
      vecs[4] = '{32'hFFFF_FFFE, 1, 15, 32'hFFFF_FFFF, 2};   // done on last legal cycle

      n_rst = 1'b1;
      in_valid = 1'b0;
      in_word = '0;
      sweep_count = '0;
      abort = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // Sequential header words, fixed hash
      stage_fixed = 1'b1;
      for (int i = 0; i < 20; i++) w[i] = i;
      run_job(w, 0, 10, 0, nres, last);
      check("t2 results", nres, 1);
      check("t2 nonce", last, 32'h13);
      stage_fixed = 1'b0;

      // Vector table
      foreach (vecs[v]) begin
         random_words(w);
         w[19] = vecs[v].w19;
         run_job(w, vecs[v].sweep, vecs[v].delay, 2, nres, last);
         check("vec results", nres, vecs[v].exp_n);
         check("vec last nonce", last, vecs[v].exp_last);
      end

      // Result held with res_ready low
      random_words(w);
      stage_delay = 4;
      base = en_count;
      send_words(w, 20, 1);
      wait_res(ok);
      if (ok) begin
         for (int c = 0; c < 5; c++) begin
            check("t4 res_valid hold", res_valid, 1);
            check("t4 res_hash stable", res_hash, model_hash(w, w[19]));
            check("t4 res_nonce stable", res_nonce, w[19]);
            check("t4 in_ready", in_ready, 0);
            check("t4 no enable", en_count - base, 1);
            @(negedge clk);
         end
         handshake();
         wait_res(ok);
         check("t4 second nonce", res_nonce, w[19] + Step);
         handshake();
      end
      check("t4 enable count", en_count - base, 2);

      // Abort in RESULT together with res_ready: result lost, sweep cancelled
      random_words(w);
      stage_delay = 2;
      base = en_count;
      send_words(w, 20, 2);
      wait_res(ok);
      res_ready = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      abort = 1'b0;
      check("abort result res_valid", res_valid, 0);
      check("abort result in_ready", in_ready, 1);
      repeat (20) @(negedge clk);
      check("abort result enables", en_count - base, 1);
      check("abort result idle", res_valid, 0);

      // Abort 3 cycles after enable -> drain until done
      random_words(w);
      stage_delay = 10;
      send_words(w, 20, 0);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      seen_valid = 1'b0;
      for (idx = 4; idx <= 16; idx++) begin
         seen_valid |= res_valid;
         if (idx == 10) check("t5 draining", in_ready, 0);
         if (idx == 11) check("t5 in_ready after done", in_ready, 1);
         @(negedge clk);
      end
      check("t5 no result", seen_valid, 0);

      // Timeout: stage never completes
      random_words(w);
      stage_delay = 0;
      send_words(w, 20, 0);
      check("t6 err before", timeout_err, 0);
      repeat (15) @(negedge clk);
      check("t6 err at 15", timeout_err, 0);
      check("t6 busy at 15", busy, 1);
      @(negedge clk);
      check("t6 err at 16", timeout_err, 1);
      check("t6 in_ready", in_ready, 1);
      check("t6 res_valid", res_valid, 0);
      repeat (5) @(negedge clk);
      check("t6 err sticky", timeout_err, 1);
      random_words(w);
      send_words(w, 1, 0);
      check("t6 err cleared by word 0", timeout_err, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // Abort mid-load, then a fresh header must load from slot 0
      random_words(w);
      send_words(w, 7, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      random_words(w);
      run_job(w, 1, 5, 1, nres, last);
      check("load abort results", nres, 2);

      // Reset held mid-WAIT
      random_words(w);
      stage_delay = 10;
      send_words(w, 20, 3);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      kill_req++;
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("t1");

      // Randomized jobs against the reference model
      for (int j = 0; j < 6; j++) begin
         int sw;
         random_words(w);
         sw = $urandom_range(3, 0);
         run_job(w, sw, $urandom_range(15, 1), 3, nres, last);
         check("rand results", nres, sw + 1);
         check("rand last nonce", last, w[19] + sw * Step);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
